// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Used by dmem_responder and dmem_sram_bank.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTE_LANES    = 8;
    localparam int WORD_OFS_BITS = 3;

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < BYTE_LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Valid/ready request and response channels of the data-memory port.
// The master side is the core's load/store path, the slave side the responder.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_be;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_be,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        output resp_ready,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_be,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        input  resp_ready,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/dmem_sram_bank.sv
// DEPTH x 64 word array: synchronous per-byte-lane write, combinational read.
// Contents are never cleared by reset.
module dmem_sram_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory slave with LATENCY wait-states.
// Optional DMEM_BOUNDS_CHECK_EN flags accesses beyond DEPTH*8 bytes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    // Loaded with LATENCY+1 so the commit edge lands LATENCY+1 after accept.
    localparam logic [4:0] CNT_LOAD = 5'(LATENCY + 1);

    state_t        state;
    logic [4:0]    cnt;
    logic          ready_q;
    logic          valid_q;
    logic [63:0]   rdata_q;
    logic          err_q;

    logic          we_q;
    logic [7:0]    be_q;
    logic [AW-1:0] idx_q;
    logic [63:0]   wdata_q;
    logic          bad_q;

    logic          bad;
    logic          commit;
    logic          bank_we;
    logic [63:0]   bank_rdata;
    logic          unused_addr;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign bad = |bus.req_addr[63:AW+WORD_OFS_BITS];
`else
    assign bad = 1'b0;
`endif

    assign unused_addr = ^{bus.req_addr[63:AW+WORD_OFS_BITS],
                           bus.req_addr[WORD_OFS_BITS-1:0]};

    assign commit  = (state == WAIT) && (cnt == 5'd1) && rst;
    assign bank_we = commit && we_q && !bad_q;

    dmem_sram_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .be    (be_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        we_q    <= bus.req_we;
                        be_q    <= bus.req_be;
                        idx_q   <= bus.req_addr[AW+WORD_OFS_BITS-1:WORD_OFS_BITS];
                        wdata_q <= bus.req_wdata;
                        bad_q   <= bad;
                        cnt     <= CNT_LOAD;
                        ready_q <= 1'b0;
                        state   <= WAIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 5'd1) begin
                        cnt     <= '0;
                        valid_q <= 1'b1;
                        err_q   <= bad_q;
                        rdata_q <= (we_q || bad_q) ? 64'd0
                                 : (bank_rdata & be_mask(be_q));
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
